// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory between the row-pass and column-pass 1D DCTs.
// Rows fill one bank while the other, already full, bank drains column by column.
module dct_transpose_buffer #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_col,
    output logic [2:0]          out_col_idx,
    output logic                out_last
);

    logic [DATA_W-1:0] mem [2][8][8];
    logic [1:0]        full;
    logic              wbank;
    logic              rbank;
    logic [2:0]        wr_row;
    logic [2:0]        rd_col;
    logic              wr_fire;
    logic              rd_fire;

    // Handshake flags decode registered state only, so ready/valid never depend on the peer.
    assign in_ready    = !full[wbank];
    assign out_valid   = full[rbank];
    assign wr_fire     = in_valid && in_ready;
    assign rd_fire     = out_valid && out_ready;
    assign out_col_idx = rd_col;
    assign out_last    = out_valid && (rd_col == 3'd7);

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        out_col = '0;
        for (int k = 0; k < 8; k++) begin
            out_col[k*DATA_W +: DATA_W] = mem[rbank][k][rd_col];
        end
    end

    // NOTE: storage sits in the async reset because a reset must leave out_col at zero;
    // sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        mem[b][r][c] <= '0;
                    end
                end
            end
            full   <= 2'b00;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            wr_row <= 3'd0;
            rd_col <= 3'd0;
        end else begin
            if (wr_fire) begin
                for (int c = 0; c < 8; c++) begin
                    mem[wbank][wr_row][c] <= in_row[c*DATA_W +: DATA_W];
                end
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wbank] <= 1'b1;
                    wbank       <= !wbank;
                end
            end
            // A firing read always targets the other bank from a firing write.
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    full[rbank] <= 1'b0;
                    rbank       <= !rbank;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: a table-driven single block,
// then hand-written sequences for streaming, backpressure, random stalls and resets.
module tb_dct_transpose_buffer;

    localparam int DATA_W = 16;
    localparam int ROW_W  = 8 * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_col;
    logic [2:0]       out_col_idx;
    logic             out_last;

    int n_vec = 0;
    int n_err = 0;

    dct_transpose_buffer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_col    (out_col),
        .out_col_idx(out_col_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_valid;
        int         row;
        logic       out_ready;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic [2:0] exp_idx;
        logic       exp_last;
    } vec_t;

    vec_t tbl [17];

    // Element c of row r of block b carries b*0x100 + r*0x10 + c.
    function automatic logic [DATA_W-1:0] pat(input int b, input int r, input int c);
        return DATA_W'(b * 256 + r * 16 + c);
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input int b, input int r);
        logic [ROW_W-1:0] v;
        for (int c = 0; c < 8; c++) v[c*DATA_W +: DATA_W] = pat(b, r, c);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] col_of(input int b, input int col);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*DATA_W +: DATA_W] = pat(b, k, col);
        return v;
    endfunction

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic feed_block(input int b);
        for (int r = 0; r < 8; r++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            in_valid = 1'b0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) check("feed_timeout", in_ready, 1);
            in_valid = 1'b1;
            in_row   = row_of(b, r);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_block(input int b);
        for (int c = 0; c < 8; c++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!out_valid && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            check("drain_valid", out_valid, 1);
            check("drain_idx", out_col_idx, c);
            check("drain_last", out_last, c == 7);
            check("drain_col", out_col, col_of(b, c));
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int               accepted;
        int               col_out;
        int               blk_out;
        int               fed;
        logic             hold;
        logic             r;
        logic [ROW_W-1:0] prev_col;
        logic [2:0]       prev_idx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_col", out_col, 0);
        check("rst_idx", out_col_idx, 0);
        check("rst_last", out_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1: one block through the table
        for (int i = 0; i < 17; i++) begin
            if (i < 8)       tbl[i] = '{1'b1, i, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
            else if (i < 16) tbl[i] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 3'(i - 8), i == 15};
            else             tbl[i] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
        end
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("t1_in_ready", in_ready, tbl[i].exp_in_ready);
            check("t1_out_valid", out_valid, tbl[i].exp_out_valid);
            if (tbl[i].exp_out_valid) begin
                check("t1_idx", out_col_idx, tbl[i].exp_idx);
                check("t1_last", out_last, tbl[i].exp_last);
                check("t1_col", out_col, col_of(0, int'(tbl[i].exp_idx)));
                if (tbl[i].exp_idx == 3'd3)
                    check("t1_col3_literal", out_col, 128'h0073_0063_0053_0043_0033_0023_0013_0003);
            end
            in_valid  = tbl[i].in_valid;
            in_row    = row_of(0, tbl[i].row);
            out_ready = tbl[i].out_ready;
        end

        // T2: three blocks streamed back to back
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            @(negedge clk);
            check("t2_out_valid", out_valid, cyc >= 8 && cyc < 32);
            if (cyc < 24) check("t2_in_ready", in_ready, 1);
            if (cyc >= 8 && cyc < 32 && out_valid) begin
                check("t2_idx", out_col_idx, (cyc - 8) % 8);
                check("t2_col", out_col, col_of((cyc - 8) / 8, (cyc - 8) % 8));
            end
            in_valid = cyc < 24;
            in_row   = row_of(cyc / 8, cyc % 8);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // T3: backpressure with both banks full, then release
        do_reset();
        accepted = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            check("t3_in_ready", in_ready, cyc < 16);
            check("t3_out_valid", out_valid, cyc >= 8);
            in_valid = 1'b1;
            in_row   = row_of(accepted / 8, accepted % 8);
            if (in_ready) accepted++;
        end
        check("t3_accepted", accepted, 16);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t3_held", in_ready, 0);
            check("t3_col_b0", out_col, col_of(0, c));
            check("t3_idx_b0", out_col_idx, c);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("t3_freed", in_ready, 1);
        check("t3_col_b1", out_col, col_of(1, 0));
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("t3_col_b1", out_col, col_of(1, c));
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("t3_partial_no_valid", out_valid, 0);
        for (int rr = 1; rr < 8; rr++) begin
            @(negedge clk);
            check("t3_refill_ready", in_ready, 1);
            in_valid = 1'b1;
            in_row   = row_of(2, rr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain_block(2);

        // T4: random out_ready over four blocks
        do_reset();
        col_out = 0;
        blk_out = 0;
        fed     = 0;
        hold    = 1'b0;
        prev_col = '0;
        prev_idx = '0;
        for (int cyc = 0; cyc < 600 && blk_out < 4; cyc++) begin
            @(negedge clk);
            if (hold) begin
                check("t4_stable_col", out_col, prev_col);
                check("t4_stable_idx", out_col_idx, prev_idx);
            end
            if (out_valid) begin
                check("t4_idx", out_col_idx, col_out);
                check("t4_col", out_col, col_of(blk_out, col_out));
            end
            r         = 1'($urandom_range(0, 1));
            out_ready = r;
            hold      = out_valid && !r;
            prev_col  = out_col;
            prev_idx  = out_col_idx;
            if (out_valid && r) begin
                if (col_out == 7) begin
                    col_out = 0;
                    blk_out++;
                end else begin
                    col_out++;
                end
            end
            if (fed < 32) begin
                in_valid = 1'b1;
                in_row   = row_of(fed / 8, fed % 8);
                if (in_ready) fed++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("t4_done", blk_out, 4);
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // T5: reset after five rows of a block
        do_reset();
        for (int rr = 0; rr < 5; rr++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_row   = row_of(7, rr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_rst_in_ready", in_ready, 1);
            check("t5_rst_out_valid", out_valid, 0);
            check("t5_rst_out_col", out_col, 0);
        end
        rst = 1'b0;
        feed_block(1);
        drain_block(1);
        @(negedge clk);
        check("t5_empty_after", out_valid, 0);

        // T6: asynchronous reset in the middle of draining
        do_reset();
        feed_block(5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_col", out_col, col_of(5, c));
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_idx", out_col_idx, 4);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_idx", out_col_idx, 0);
        check("t6_async_col", out_col, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_idle_valid", out_valid, 0);
        end
        for (int rr = 0; rr < 8; rr++) begin
            @(negedge clk);
            check("t6_fill_valid", out_valid, 0);
            in_valid = 1'b1;
            in_row   = row_of(6, rr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_full_valid", out_valid, 1);
        drain_block(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
